// File: rtl/memristor_prog_ctrl.sv
// Write-verify programming controller for a single memristor cell.
// Optional amplitude ramp enabled by defining MEMPROG_ADAPTIVE_EN.
module memristor_prog_ctrl #(
    parameter real V_READ     = 0.2,
    parameter real V_SET      = 1.0,
    parameter real V_RESET    = -1.0,
    parameter int  SETTLE_CYC = 2,
    parameter int  PULSE_CYC  = 4,
    parameter int  MAX_PULSES = 32,
    parameter real V_STEP     = 0.1,
    parameter real V_MAX      = 2.0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  real        r_target,
    input  real        r_tol,
    input  real        i_sense,
    output real        v_drive,
    output real        r_meas,
    output logic [5:0] pulse_count,
    output logic       busy,
    output logic       done,
    output logic       fail
);

`ifdef MEMPROG_ADAPTIVE_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, READ, CHECK, PULSE, DONE, FAIL
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    real         r_tgt;
    real         r_tl;
    real         cur_mag;
    logic        last_pol;
    logic        have_pulse;

    logic        pol_pos;
    logic        in_band;
    real         base_mag;
    real         grown;
    real         mag;
    real         pulse_v;
    real         diff;

    // Acceptance test and next pulse amplitude, evaluated from the latest reading.
    always_comb begin
        pol_pos  = r_meas > r_tgt;
        diff     = r_meas - r_tgt;
        if (diff < 0.0)
            diff = -diff;
        in_band  = diff <= r_tl;
        base_mag = pol_pos ? V_SET : -V_RESET;
        grown    = cur_mag + V_STEP;
        if (grown > V_MAX)
            grown = V_MAX;
        if (ADAPT && have_pulse && (last_pol == pol_pos))
            mag = grown;
        else
            mag = base_mag;
        pulse_v = pol_pos ? mag : -mag;
    end

    // Operation sequencer; every output is registered and set on the edge entering a state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            v_drive     <= 0.0;
            r_meas      <= 0.0;
            pulse_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            r_tgt       <= 0.0;
            r_tl        <= 0.0;
            cur_mag     <= 0.0;
            last_pol    <= 1'b0;
            have_pulse  <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            unique case (state)
                IDLE: begin
                    v_drive <= 0.0;
                    if (start) begin
                        r_tgt       <= r_target;
                        r_tl        <= r_tol;
                        pulse_count <= '0;
                        have_pulse  <= 1'b0;
                        cnt         <= '0;
                        v_drive     <= V_READ;
                        busy        <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (cnt == 16'(SETTLE_CYC - 1)) begin
                        if (i_sense <= 0.0)
                            r_meas <= 1.0e12;
                        else
                            r_meas <= V_READ / i_sense;
                        v_drive <= 0.0;
                        cnt     <= '0;
                        state   <= CHECK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CHECK: begin
                    if (in_band) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (pulse_count == 6'(MAX_PULSES)) begin
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                        state <= FAIL;
                    end else begin
                        v_drive    <= pulse_v;
                        cur_mag    <= mag;
                        last_pol   <= pol_pos;
                        have_pulse <= 1'b1;
                        cnt        <= '0;
                        state      <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == 16'(PULSE_CYC - 1)) begin
                        pulse_count <= pulse_count + 6'd1;
                        v_drive     <= V_READ;
                        cnt         <= '0;
                        state       <= READ;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE, FAIL: begin
                    v_drive <= 0.0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memristor_prog_ctrl.sv
// Scoreboard bench for memristor_prog_ctrl with a behavioural cell stub.
// Expected pulse amplitudes follow MEMPROG_ADAPTIVE_EN when it is defined.
module tb_memristor_prog_ctrl;

`ifdef MEMPROG_ADAPTIVE_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif
    localparam real V_RD = 0.2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    real        r_target = 0.0;
    real        r_tol = 0.0;
    real        i_sense;
    real        v_drive;
    real        r_meas;
    logic [5:0] pulse_count;
    logic       busy;
    logic       done;
    logic       fail;

    int compared = 0;
    int mismatched = 0;
    int strobes = 0;

    real r_cell = 8050.0;
    real dset = 0.0;
    real dreset = 0.0;
    bit  open_cell = 1'b0;

    typedef struct {
        bit  pass;
        int  pc;
        real rm;
        int  n;
        real sgn;
    } exp_t;

    exp_t exp_q[$];
    real  amps[$];

    memristor_prog_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .r_target(r_target),
        .r_tol(r_tol),
        .i_sense(i_sense),
        .v_drive(v_drive),
        .r_meas(r_meas),
        .pulse_count(pulse_count),
        .busy(busy),
        .done(done),
        .fail(fail)
    );

    always #5 clk = ~clk;

    always_comb i_sense = open_cell ? 0.0 : V_RD / r_cell;

    function automatic bit near(real a, real b);
        real d;
        real lim;
        d = a - b;
        if (d < 0.0) d = -d;
        lim = (b < 0.0) ? -b : b;
        return d <= (1.0e-6 * lim + 1.0e-9);
    endfunction

    task automatic chk_int(string name, int act, int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic chk_real(string name, real act, real req);
        compared++;
        if (!near(act, req)) begin
            mismatched++;
            $display("FAIL %s: got %g want %g", name, act, req);
        end
    endtask

    // Monitor: tracks pulses, updates the cell stub, checks each done/fail strobe.
    real prev_v = 0.0;
    int  prev_pc = 0;
    always @(negedge clk) begin
        if (rst) begin
            amps.delete();
        end else begin
            if (prev_v == 0.0 && v_drive != 0.0 && v_drive != V_RD)
                amps.push_back(v_drive);
            if (int'(pulse_count) == prev_pc + 1 && amps.size() > 0) begin
                if (amps[$] > 0.0) r_cell = r_cell - dset;
                else r_cell = r_cell + dreset;
            end
            if (done || fail) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_strobe: done=%0b fail=%0b", done, fail);
                end else begin
                    exp_t e;
                    bit bad;
                    real want;
                    e = exp_q.pop_front();
                    chk_int("done", int'(done), int'(e.pass));
                    chk_int("fail", int'(fail), int'(!e.pass));
                    chk_int("pulse_count", int'(pulse_count), e.pc);
                    chk_real("r_meas", r_meas, e.rm);
                    chk_int("num_pulses", amps.size(), e.n);
                    bad = 1'b0;
                    for (int k = 0; k < amps.size() && k < e.n; k++) begin
                        want = ADAPT ? 1.0 + 0.1 * k : 1.0;
                        if (want > 2.0) want = 2.0;
                        want = want * e.sgn;
                        if (!bad && !near(amps[k], want)) begin
                            bad = 1'b1;
                            $display("FAIL amplitude[%0d]: got %g want %g", k, amps[k], want);
                        end
                    end
                    compared++;
                    if (bad) mismatched++;
                end
                amps.delete();
            end
        end
        prev_v = v_drive;
        prev_pc = int'(pulse_count);
    end

    task automatic issue(real tgt, real tol, bit pass, int pc, real rm, int n, real sgn);
        exp_t e;
        e.pass = pass;
        e.pc = pc;
        e.rm = rm;
        e.n = n;
        e.sgn = sgn;
        exp_q.push_back(e);
        r_target = tgt;
        r_tol = tol;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(int s0, string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (strobes != s0) break;
            @(negedge clk);
        end
        if (strobes == s0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: strobes %0d want %0d", name, strobes, s0 + 1);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    real vexp[4] = '{0.2, 0.2, 0.0, 0.0};

    initial begin
        int s0;
        int i;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_pc", int'(pulse_count), 0);
        chk_real("rst_v", v_drive, 0.0);
        chk_real("rst_rmeas", r_meas, 0.0);
        chk_int("rst_done_fail", int'(done | fail), 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_int("idle_busy", int'(busy), 0);

        // In-band: no pulse, 4-cycle latency, only read voltage applied.
        r_cell = 8050.0;
        s0 = strobes;
        r_target = 8000.0;
        r_tol = 100.0;
        begin
            exp_t e;
            e.pass = 1'b1; e.pc = 0; e.rm = 8050.0; e.n = 0; e.sgn = 1.0;
            exp_q.push_back(e);
        end
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk_real($sformatf("inband_v_c%0d", k + 1), v_drive, vexp[k]);
            chk_int($sformatf("inband_done_c%0d", k + 1), int'(done), (k == 3) ? 1 : 0);
        end
        wait_end(s0, "inband");

        // High R: five SET pulses down to 7050.
        r_cell = 8050.0; dset = 200.0; dreset = 0.0;
        s0 = strobes;
        issue(7000.0, 100.0, 1'b1, 5, 7050.0, 5, 1.0);
        wait_end(s0, "high_r");

        // Low R: four RESET pulses up to 6000.
        r_cell = 5000.0; dset = 0.0; dreset = 250.0;
        s0 = strobes;
        issue(6000.0, 100.0, 1'b1, 4, 6000.0, 4, -1.0);
        wait_end(s0, "low_r");

        // Non-convergent: budget exhausted.
        r_cell = 16000.0; dset = 0.0; dreset = 0.0;
        s0 = strobes;
        issue(100.0, 10.0, 1'b0, 32, 16000.0, 32, 1.0);
        wait_end(s0, "nonconv");

        // Open cell: reads as 1e12, SET pulses until budget runs out.
        open_cell = 1'b1;
        s0 = strobes;
        issue(8000.0, 100.0, 1'b0, 32, 1.0e12, 32, 1.0);
        wait_end(s0, "open");
        open_cell = 1'b0;

        // Reset on the 2nd cycle of the 3rd pulse, with start held alongside.
        r_cell = 8050.0; dset = 200.0;
        r_target = 7000.0; r_tol = 100.0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (i = 0; i < 500; i++) begin
            if (pulse_count == 6'd2 && v_drive > 0.5) break;
            @(negedge clk);
        end
        chk_int("abort_reach_pulse", int'(pulse_count), 2);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_real("abort_v", v_drive, 0.0);
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_pc", int'(pulse_count), 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_int("abort_stay_idle", int'(busy), 0);
        chk_int("abort_no_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
